// File: rtl/is2vid_av_st_input.sv
// is2vid_av_st_input
//   Avalon-ST video sink feeding the clock-crossing FIFO of the video output.
//   Video packets (type 0) are forwarded as {data, packet-end flag} words.
//   Control packets (type 15) are decoded into width/height/interlace.
//   All other packet types are dropped.
// Ports
//   rst, is_clk              : async active-high reset, sink clock
//   is_data/valid/sop/eop    : Avalon-ST sink (ready latency 1)
//   is_ready                 : sink ready, registered from ~fifo_almost_full
//   wrdata, wrreq            : FIFO write port
//   fifo_almost_full/full    : FIFO status
//   overflow_clear, overflow : sticky overflow flag and its clear
//   ctrl_width/height/interlace, ctrl_update, ctrl_error : control decode
//   sync_error               : pulse on a beat outside a packet or a sop inside one
module is2vid_av_st_input #(
   parameter int DATA_WIDTH                          = 20,
   parameter int FIFO_WIDTH                          = 21,
   parameter int NUMBER_OF_COLOUR_PLANES_IN_PARALLEL = 2,
   parameter int BPS                                 = 10
) (
   input  logic                  rst,
   input  logic                  is_clk,
   input  logic [DATA_WIDTH-1:0] is_data,
   input  logic                  is_valid,
   input  logic                  is_sop,
   input  logic                  is_eop,
   output logic                  is_ready,
   output logic [FIFO_WIDTH-1:0] wrdata,
   output logic                  wrreq,
   input  logic                  fifo_almost_full,
   input  logic                  fifo_full,
   input  logic                  overflow_clear,
   output logic [15:0]           ctrl_width,
   output logic [15:0]           ctrl_height,
   output logic [3:0]            ctrl_interlace,
   output logic                  ctrl_update,
   output logic                  ctrl_error,
   output logic                  sync_error,
   output logic                  overflow
);

   localparam int N = NUMBER_OF_COLOUR_PLANES_IN_PARALLEL;

   typedef enum logic [1:0] {S_IDLE, S_VIDEO, S_CONTROL, S_DISCARD} state_t;

   state_t r_state, w_state_nxt;

   logic w_sync_err, w_video_beat, w_ctrl_beat, w_ctrl_sop;

   // hold register: one video word waiting for its end flag to be known
   logic [DATA_WIDTH-1:0] r_held_data;
   logic                  r_held_eop, r_held_valid;
   logic                  w_wr, w_flag;

   // control decode shadow registers, committed on a complete packet
   logic [15:0] r_sh_w, r_sh_h, w_sh_w, w_sh_h;
   logic [3:0]  r_sh_i, w_sh_i;
   logic [3:0]  r_cnt, w_cnt;
   logic [4:0]  w_k, w_sum;
   logic [3:0]  w_nib;

   logic r_ready, r_sync_error, r_ctrl_update, r_ctrl_error, r_overflow;
   logic [15:0] r_ctrl_width, r_ctrl_height;
   logic [3:0]  r_ctrl_interlace;

   always_ff @(posedge is_clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_sync_err   = 1'b0;
      w_video_beat = 1'b0;
      w_ctrl_beat  = 1'b0;
      w_ctrl_sop   = 1'b0;
      if (is_valid) begin
         if (is_sop) begin
            // a sop always starts a new packet, abandoning any open one
            w_sync_err = (r_state != S_IDLE);
            case (is_data[3:0])
               4'h0: begin w_state_nxt = S_VIDEO;   w_video_beat = 1'b1; end
               4'hF: begin w_state_nxt = S_CONTROL; w_ctrl_sop   = 1'b1; end
               default:    w_state_nxt = S_DISCARD;
            endcase
         end else begin
            case (r_state)
               S_IDLE:    w_sync_err   = 1'b1;
               S_VIDEO:   w_video_beat = 1'b1;
               S_CONTROL: w_ctrl_beat  = 1'b1;
               default:   ;
            endcase
         end
         if (is_eop) w_state_nxt = S_IDLE;
      end
   end

   // Held word goes out once its successor arrives or it is the last word.
   // A sop arriving on top of an unfinished packet closes it with flag 1.
   assign w_wr   = r_held_valid & (r_held_eop | is_valid);
   assign w_flag = r_held_eop | (is_valid & is_sop);
   assign wrreq  = w_wr;
   assign wrdata = w_wr ? {r_held_data, w_flag} : '0;

   always_ff @(posedge is_clk or posedge rst) begin
      if (rst) begin
         r_held_data  <= '0;
         r_held_eop   <= 1'b0;
         r_held_valid <= 1'b0;
      end else if (w_video_beat) begin
         r_held_data  <= is_data;
         r_held_eop   <= is_eop;
         r_held_valid <= 1'b1;
      end else if (w_wr) begin
         r_held_valid <= 1'b0;
      end
   end

   // nibble k = count + lane; nibbles past 8 are ignored
   always_comb begin
      w_sh_w = r_sh_w;
      w_sh_h = r_sh_h;
      w_sh_i = r_sh_i;
      w_cnt  = r_cnt;
      w_k    = '0;
      w_nib  = '0;
      w_sum  = {1'b0, r_cnt} + 5'(N);
      if (w_ctrl_beat) begin
         for (int i = 0; i < N; i++) begin
            w_nib = is_data[BPS*i +: 4];
            w_k   = {1'b0, r_cnt} + 5'(i);
            case (w_k)
               5'd0: w_sh_w[15:12] = w_nib;
               5'd1: w_sh_w[11:8]  = w_nib;
               5'd2: w_sh_w[7:4]   = w_nib;
               5'd3: w_sh_w[3:0]   = w_nib;
               5'd4: w_sh_h[15:12] = w_nib;
               5'd5: w_sh_h[11:8]  = w_nib;
               5'd6: w_sh_h[7:4]   = w_nib;
               5'd7: w_sh_h[3:0]   = w_nib;
               5'd8: w_sh_i        = w_nib;
               default: ;
            endcase
         end
         w_cnt = (w_sum > 5'd9) ? 4'd9 : w_sum[3:0];
      end
   end

   always_ff @(posedge is_clk or posedge rst) begin
      if (rst) begin
         r_sh_w           <= '0;
         r_sh_h           <= '0;
         r_sh_i           <= '0;
         r_cnt            <= '0;
         r_ctrl_width     <= '0;
         r_ctrl_height    <= '0;
         r_ctrl_interlace <= '0;
         r_ctrl_update    <= 1'b0;
         r_ctrl_error     <= 1'b0;
         r_sync_error     <= 1'b0;
         r_ready          <= 1'b0;
         r_overflow       <= 1'b0;
      end else begin
         r_ctrl_update <= 1'b0;
         r_ctrl_error  <= 1'b0;
         r_sync_error  <= w_sync_err;
         r_ready       <= ~fifo_almost_full;
         if (w_ctrl_sop) begin
            r_cnt <= '0;
            if (is_eop) r_ctrl_error <= 1'b1;
         end else if (w_ctrl_beat) begin
            r_sh_w <= w_sh_w;
            r_sh_h <= w_sh_h;
            r_sh_i <= w_sh_i;
            r_cnt  <= w_cnt;
            if (is_eop) begin
               if (w_cnt == 4'd9) begin
                  r_ctrl_width     <= w_sh_w;
                  r_ctrl_height    <= w_sh_h;
                  r_ctrl_interlace <= w_sh_i;
                  r_ctrl_update    <= 1'b1;
               end else begin
                  r_ctrl_error     <= 1'b1;
               end
            end
         end
         // set wins over clear
         if (w_wr & fifo_full)   r_overflow <= 1'b1;
         else if (overflow_clear) r_overflow <= 1'b0;
      end
   end

   assign is_ready       = r_ready;
   assign ctrl_width     = r_ctrl_width;
   assign ctrl_height    = r_ctrl_height;
   assign ctrl_interlace = r_ctrl_interlace;
   assign ctrl_update    = r_ctrl_update;
   assign ctrl_error     = r_ctrl_error;
   assign sync_error     = r_sync_error;
   assign overflow       = r_overflow;

endmodule

// File: tb/tb_is2vid_av_st_input.sv
// tb_is2vid_av_st_input
//   Directed bench for is2vid_av_st_input with the default parameters
//   (N=2, BPS=10). FIFO writes are logged with their cycle number by a
//   negedge recorder; the main sequence compares against hand-computed values.
module tb_is2vid_av_st_input;

   logic        rst, is_clk;
   logic [19:0] is_data;
   logic        is_valid, is_sop, is_eop, is_ready;
   logic [20:0] wrdata;
   logic        wrreq, fifo_almost_full, fifo_full, overflow_clear;
   logic [15:0] ctrl_width, ctrl_height;
   logic [3:0]  ctrl_interlace;
   logic        ctrl_update, ctrl_error, sync_error, overflow;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [20:0] wlog[$];
   int          wcyc[$];

   is2vid_av_st_input dut (
      .rst(rst), .is_clk(is_clk), .is_data(is_data), .is_valid(is_valid),
      .is_sop(is_sop), .is_eop(is_eop), .is_ready(is_ready),
      .wrdata(wrdata), .wrreq(wrreq), .fifo_almost_full(fifo_almost_full),
      .fifo_full(fifo_full), .overflow_clear(overflow_clear),
      .ctrl_width(ctrl_width), .ctrl_height(ctrl_height),
      .ctrl_interlace(ctrl_interlace), .ctrl_update(ctrl_update),
      .ctrl_error(ctrl_error), .sync_error(sync_error), .overflow(overflow)
   );

   initial is_clk = 1'b0;
   always #5 is_clk = ~is_clk;

   always @(posedge is_clk) cyc <= cyc + 1;

   always @(negedge is_clk) begin
      if (wrreq === 1'b1) begin
         wlog.push_back(wrdata);
         wcyc.push_back(cyc);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge is_clk); #1;
   endtask

   task automatic beat(input logic [19:0] d, input logic s, input logic e);
      tick();
      is_valid = 1'b1; is_sop = s; is_eop = e; is_data = d;
   endtask

   task automatic idle();
      tick();
      is_valid = 1'b0; is_sop = 1'b0; is_eop = 1'b0; is_data = '0;
   endtask

   int n0, ecyc;

   initial begin
      rst = 1'b1; is_valid = 1'b0; is_sop = 1'b0; is_eop = 1'b0; is_data = '0;
      fifo_almost_full = 1'b0; fifo_full = 1'b0; overflow_clear = 1'b0;
      tick(); tick(); tick();
      chk("rst_ready",  32'(is_ready), 0);
      chk("rst_wrreq",  32'(wrreq), 0);
      chk("rst_wrdata", 32'(wrdata), 0);
      chk("rst_width",  32'(ctrl_width), 0);
      chk("rst_height", 32'(ctrl_height), 0);
      chk("rst_il",     32'(ctrl_interlace), 0);
      chk("rst_upd",    32'(ctrl_update), 0);
      chk("rst_cerr",   32'(ctrl_error), 0);
      chk("rst_serr",   32'(sync_error), 0);
      chk("rst_ovf",    32'(overflow), 0);
      rst = 1'b0;
      chk("ready_at_release", 32'(is_ready), 0);
      tick();
      chk("ready_after_release", 32'(is_ready), 1);

      // control packet 640x480
      n0 = wlog.size();
      beat(20'h0000F, 1, 0);
      beat(20'h00800, 0, 0);
      beat(20'h00008, 0, 0);
      beat(20'h00400, 0, 0);
      beat(20'h0000E, 0, 0);
      beat(20'h00000, 0, 1);
      idle();
      chk("c1_update", 32'(ctrl_update), 1);
      chk("c1_error",  32'(ctrl_error), 0);
      chk("c1_width",  32'(ctrl_width), 640);
      chk("c1_height", 32'(ctrl_height), 480);
      chk("c1_il",     32'(ctrl_interlace), 0);
      idle();
      chk("c1_update_pulse", 32'(ctrl_update), 0);
      chk("c1_no_writes", 32'(wlog.size()), 32'(n0));

      // video packet
      n0 = wlog.size();
      beat(20'h00000, 1, 0);
      beat(20'h12345, 0, 0);
      beat(20'h0ABCD, 0, 1);
      ecyc = cyc;
      idle(); idle(); idle();
      chk("v_count", 32'(wlog.size()), 32'(n0 + 3));
      chk("v_w0", 32'(wlog[n0]),   32'h00000);
      chk("v_w1", 32'(wlog[n0+1]), 32'h2468A);
      chk("v_w2", 32'(wlog[n0+2]), 32'h1579B);
      chk("v_last_cycle", 32'(wcyc[n0+2]), 32'(ecyc + 1));
      chk("v_first_cycle", 32'(wcyc[n0]), 32'(ecyc - 1));

      // video cut by a control sop, then decode 0x1234 x 0x5678, interlace 9
      n0 = wlog.size();
      beat(20'h00000, 1, 0);
      beat(20'h11111, 0, 0);
      beat(20'h0000F, 1, 0);
      beat(20'h00801, 0, 0);
      chk("cut_sync_err", 32'(sync_error), 1);
      beat(20'h01003, 0, 0);
      chk("cut_sync_err_pulse", 32'(sync_error), 0);
      beat(20'h01805, 0, 0);
      beat(20'h02007, 0, 0);
      beat(20'h03C09, 0, 1);
      idle();
      chk("cut_update", 32'(ctrl_update), 1);
      chk("cut_width",  32'(ctrl_width), 32'h1234);
      chk("cut_height", 32'(ctrl_height), 32'h5678);
      chk("cut_il",     32'(ctrl_interlace), 9);
      chk("cut_count",  32'(wlog.size()), 32'(n0 + 2));
      chk("cut_w0",     32'(wlog[n0]),   32'h00000);
      chk("cut_w1",     32'(wlog[n0+1]), 32'h22223);

      // short control packet
      beat(20'h0000F, 1, 0);
      beat(20'h00000, 0, 0);
      beat(20'h00000, 0, 0);
      beat(20'h00000, 0, 1);
      idle();
      chk("short_error",  32'(ctrl_error), 1);
      chk("short_update", 32'(ctrl_update), 0);
      chk("short_width",  32'(ctrl_width), 32'h1234);
      chk("short_height", 32'(ctrl_height), 32'h5678);
      idle();
      chk("short_error_pulse", 32'(ctrl_error), 0);

      // type 3 packet dropped
      n0 = wlog.size();
      beat(20'h00003, 1, 0);
      beat(20'h12340, 0, 0);
      beat(20'h23450, 0, 0);
      beat(20'h34560, 0, 0);
      beat(20'h45670, 0, 1);
      idle(); idle();
      chk("discard_no_writes", 32'(wlog.size()), 32'(n0));
      chk("discard_no_serr",   32'(sync_error), 0);

      // almost full throttles ready one cycle later
      fifo_almost_full = 1'b1;
      tick();
      chk("af_ready_low", 32'(is_ready), 0);
      fifo_almost_full = 1'b0;
      tick();
      chk("af_ready_back", 32'(is_ready), 1);

      // overflow sticky until cleared
      fifo_full = 1'b1;
      beat(20'h55550, 1, 1);
      idle();
      chk("ovf_wrreq", 32'(wrreq), 1);
      chk("ovf_wrdata", 32'(wrdata), 32'hAAAA1);
      chk("ovf_before", 32'(overflow), 0);
      idle();
      chk("ovf_set", 32'(overflow), 1);
      fifo_full = 1'b0;
      idle(); idle();
      chk("ovf_sticky", 32'(overflow), 1);
      overflow_clear = 1'b1;
      tick();
      overflow_clear = 1'b0;
      chk("ovf_cleared", 32'(overflow), 0);

      // non-sop beat in idle
      n0 = wlog.size();
      beat(20'h00120, 0, 0);
      idle();
      chk("idle_serr", 32'(sync_error), 1);
      chk("idle_dropped", 32'(wlog.size()), 32'(n0));

      // reset during video: held word is discarded
      n0 = wlog.size();
      beat(20'h00000, 1, 0);
      beat(20'h22220, 0, 0);
      tick();
      is_valid = 1'b0; is_sop = 1'b0; is_eop = 1'b0; is_data = '0;
      rst = 1'b1;
      #1;
      chk("rv_wrreq", 32'(wrreq), 0);
      chk("rv_ready", 32'(is_ready), 0);
      chk("rv_width", 32'(ctrl_width), 0);
      chk("rv_height", 32'(ctrl_height), 0);
      chk("rv_il", 32'(ctrl_interlace), 0);
      tick(); tick();
      rst = 1'b0;
      idle(); idle(); idle();
      chk("rv_writes", 32'(wlog.size()), 32'(n0 + 1));
      chk("rv_w0", 32'(wlog[n0]), 32'h00000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
